sweep_calibrator: RTL and testbench

- Parametrised N-axis calibration sweep engine; successor to the fixed 2-axis (H/V) calibration flow driven by BTN_C in sp_optimizer.
- On start, sweeps each axis in turn from POS_MIN to POS_MAX in STEP increments, waits a settle time per point, samples the panel voltage, then parks the axis at the maximum-voltage position.
- Feeds servo PWM generators through pos_out; gets its voltage from the XADC V_in path.

---
 rtl/sweep_calibrator.sv | 218 +++++++++++++++++++++
 tb/tb_sweep_calibrator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_calibrator.sv
// -----------------------------------------------------------------------------
// sweep_calibrator
//
// N-axis calibration sweep engine. On start, each axis is swept in turn
// (axis 0 first) from POS_MIN towards POS_MAX in STEP increments. The engine
// waits SETTLE_CYC cycles after every move, samples the panel voltage, and
// finally parks the axis at the position that produced the highest voltage.
// An abort restores every axis to the position it held before start.
//
// Optional feature (macro MAX_HYST_EN):
//   defined   -> a new maximum must beat the stored best by more than HYST
//                ADC LSBs; the first point of every axis always updates.
//   undefined -> plain strict "greater than" comparison; HYST has no effect.
//
// Ports:
//   CLK        system clock
//   RST        synchronous, active-high reset
//   start      begin a sweep (sampled only in IDLE)
//   abort      cancel a running sweep and restore pre-start positions
//   v_in       panel voltage sample, valid every cycle
//   pos_out    axis k position at bits [k*POS_W +: POS_W]
//   max_v_out  axis k best voltage at bits [k*ADC_W +: ADC_W]
//   axis_idx   axis currently swept (0 in IDLE)
//   busy       high in every state except IDLE
//   done       one-cycle pulse on successful completion
//   aborted    one-cycle pulse when an abort is taken
// -----------------------------------------------------------------------------
module sweep_calibrator #(
  parameter int unsigned N_AXES     = 2,
  parameter int unsigned POS_W      = 32,
  parameter int unsigned ADC_W      = 12,
  parameter int unsigned POS_MIN    = 50000,
  parameter int unsigned POS_MAX    = 250000,
  parameter int unsigned POS_CENTER = 150000,
  parameter int unsigned STEP       = 1000,
  parameter int unsigned SETTLE_CYC = 100000,
  parameter int unsigned HYST       = 4,
  localparam int unsigned AXIS_W    = (N_AXES > 1) ? $clog2(N_AXES) : 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADC_W-1:0]          v_in,
  output logic [N_AXES*POS_W-1:0]   pos_out,
  output logic [N_AXES*ADC_W-1:0]   max_v_out,
  output logic [AXIS_W-1:0]         axis_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted
);

`ifdef MAX_HYST_EN
  localparam bit HYST_ENABLED = 1'b1;
`else
  localparam bit HYST_ENABLED = 1'b0;
`endif

  // With the feature disabled the threshold collapses to zero, leaving a
  // plain strict comparison.
  localparam int unsigned HYST_ADD = HYST_ENABLED ? HYST : 0;

  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [POS_W-1:0]  POS_MIN_C    = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0]  POS_CENTER_C = POS_W'(POS_CENTER);
  localparam logic [POS_W:0]    POS_MAX_W    = (POS_W+1)'(POS_MAX);
  localparam logic [POS_W:0]    STEP_W       = (POS_W+1)'(STEP);
  localparam logic [ADC_W:0]    HYST_W       = (ADC_W+1)'(HYST_ADD);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(SETTLE_CYC - 1);
  localparam logic [AXIS_W-1:0] AXIS_LAST    = AXIS_W'(N_AXES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_PARK,
    S_DONE
  } state_t;

  state_t                          state_q;
  logic [N_AXES-1:0][POS_W-1:0]    pos_q;
  logic [N_AXES-1:0][POS_W-1:0]    restore_q;
  logic [N_AXES-1:0][ADC_W-1:0]    maxv_q;
  logic [AXIS_W-1:0]               axis_q;
  logic [ADC_W-1:0]                best_v_q;
  logic [POS_W-1:0]                best_pos_q;
  logic [CNT_W-1:0]                cnt_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            aborted_q;

  // Combinational helpers for the SAMPLE and PARK decisions.
  logic [POS_W-1:0] cur_pos;
  logic [POS_W:0]   step_pos_d;   // one extra bit so the step never wraps
  logic             past_end;
  logic [ADC_W:0]   thresh;       // one extra bit so best_v + HYST never wraps
  logic             first_pt;
  logic             take_sample;
  logic [AXIS_W-1:0] axis_d;

  // NOTE: every output of an always_comb gets a value on every path (here by
  // plain unconditional assignment) so no latch is inferred.
  always_comb begin
    cur_pos     = pos_q[axis_q];
    step_pos_d  = {1'b0, cur_pos} + STEP_W;
    past_end    = (step_pos_d > POS_MAX_W);
    thresh      = {1'b0, best_v_q} + HYST_W;
    // The first point of an axis is always sampled at POS_MIN.
    first_pt    = HYST_ENABLED && (cur_pos == POS_MIN_C);
    take_sample = first_pt || ({1'b0, v_in} > thresh);
    axis_d      = axis_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      pos_q      <= {N_AXES{POS_CENTER_C}};
      maxv_q     <= '0;
      axis_q     <= '0;
      best_v_q   <= '0;
      best_pos_q <= POS_MIN_C;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        // Abort wins over whatever the sweep was doing this cycle.
        state_q   <= S_IDLE;
        pos_q     <= restore_q;
        axis_q    <= '0;
        cnt_q     <= '0;
        busy_q    <= 1'b0;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              axis_q     <= '0;
              pos_q[0]   <= POS_MIN_C;
              best_v_q   <= '0;
              best_pos_q <= POS_MIN_C;
              cnt_q      <= '0;
              busy_q     <= 1'b1;
              state_q    <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= S_SAMPLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_SAMPLE: begin
            // Strict comparison: ties keep the earlier, lower position.
            if (take_sample) begin
              best_v_q   <= v_in;
              best_pos_q <= cur_pos;
            end
            if (past_end) begin
              state_q <= S_PARK;
            end else begin
              pos_q[axis_q] <= step_pos_d[POS_W-1:0];
              state_q       <= S_SETTLE;
            end
          end
          S_PARK: begin
            pos_q[axis_q]  <= best_pos_q;
            maxv_q[axis_q] <= best_v_q;
            if (axis_q == AXIS_LAST) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              axis_q        <= axis_d;
              pos_q[axis_d] <= POS_MIN_C;
              best_v_q      <= '0;
              best_pos_q    <= POS_MIN_C;
              state_q       <= S_SETTLE;
            end
          end
          S_DONE: begin
            axis_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            axis_q  <= '0;
          end
        endcase
      end
    end
  end

  // NOTE: the restore buffer is plain storage with no reset; it is always
  // written at start before anything can read it back on abort.
  always_ff @(posedge CLK) begin
    if (!RST && state_q == S_IDLE && start && !abort) begin
      restore_q <= pos_q;
    end
  end

  assign pos_out   = pos_q;
  assign max_v_out = maxv_q;
  assign axis_idx  = axis_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_sweep_calibrator.sv
// -----------------------------------------------------------------------------
// tb_sweep_calibrator
//
// Directed bench for sweep_calibrator. Two instances share start/abort/reset:
// dut_a sweeps an aligned range (POS_MAX=40), dut_b a non-aligned one
// (POS_MAX=45). Each instance gets a voltage computed from its own current
// axis and position through a selectable profile.
// -----------------------------------------------------------------------------
module tb_sweep_calibrator;

  localparam int unsigned POS_W  = 32;
  localparam int unsigned ADC_W  = 12;
  localparam int unsigned CENTER = 150000;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b0;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic [ADC_W-1:0]      v_in_a, v_in_b;
  logic [2*POS_W-1:0]    pos_a, pos_b;
  logic [2*ADC_W-1:0]    maxv_a, maxv_b;
  logic                  ax_a, ax_b;
  logic                  busy_a, busy_b, done_a, done_b, abt_a, abt_b;

  int mode = 0;
  int n_vec = 0;
  int n_miss = 0;

  always #5 CLK = ~CLK;

  sweep_calibrator #(
    .N_AXES(2), .POS_W(POS_W), .ADC_W(ADC_W), .POS_MIN(0), .POS_MAX(40),
    .POS_CENTER(CENTER), .STEP(10), .SETTLE_CYC(3), .HYST(4)
  ) dut_a (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .v_in(v_in_a),
    .pos_out(pos_a), .max_v_out(maxv_a), .axis_idx(ax_a), .busy(busy_a),
    .done(done_a), .aborted(abt_a)
  );

  sweep_calibrator #(
    .N_AXES(2), .POS_W(POS_W), .ADC_W(ADC_W), .POS_MIN(0), .POS_MAX(45),
    .POS_CENTER(CENTER), .STEP(10), .SETTLE_CYC(3), .HYST(4)
  ) dut_b (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .v_in(v_in_b),
    .pos_out(pos_b), .max_v_out(maxv_b), .axis_idx(ax_b), .busy(busy_b),
    .done(done_b), .aborted(abt_b)
  );

  // Voltage profiles indexed by (axis, position).
  function automatic logic [ADC_W-1:0] prof(input int m, input logic ax,
                                            input logic [POS_W-1:0] p);
    logic [ADC_W-1:0] v;
    v = '0;
    case (m)
      0: begin
        if (!ax) begin
          case (p)
            0: v = 100; 10: v = 300; 20: v = 900; 30: v = 400; 40: v = 200;
            default: v = 0;
          endcase
        end else begin
          case (p)
            0: v = 50; 10: v = 60; 20: v = 70; 30: v = 80; 40: v = 700;
            default: v = 0;
          endcase
        end
      end
      1: v = 512;
      2: if (!ax) begin
           case (p)
             0: v = 100; 10: v = 103; 20: v = 110;
             default: v = 0;
           endcase
         end
      3: if (!ax) begin
           case (p)
             0: v = 100; 10: v = 103;
             default: v = 0;
           endcase
         end
      default: v = 0;
    endcase
    return v;
  endfunction

  logic [POS_W-1:0] word_a, word_b;
  always_comb begin
    word_a = pos_a[ax_a*POS_W +: POS_W];
    word_b = pos_b[ax_b*POS_W +: POS_W];
    v_in_a = prof(mode, ax_a, word_a);
    v_in_b = prof(mode, ax_b, word_b);
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Starts a sweep (start sampled at edge 0, so the next period is cycle 1)
  // and watches both instances through cycle 50.
  task automatic run_sweep(input string tag);
    int dc_a, dc_b, dn_a, dn_b, bl_a, bl_b;
    logic [POS_W-1:0] mx_a, mx_b;
    dc_a = 0; dc_b = 0; dn_a = 0; dn_b = 0; bl_a = 0; bl_b = 0;
    mx_a = '0; mx_b = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      if (done_a) begin dn_a++; if (dc_a == 0) dc_a = c; end
      if (done_b) begin dn_b++; if (dc_b == 0) dc_b = c; end
      if (!busy_a && bl_a == 0) bl_a = c;
      if (!busy_b && bl_b == 0) bl_b = c;
      if (busy_a && word_a > mx_a) mx_a = word_a;
      if (busy_b && word_b > mx_b) mx_b = word_b;
      if (c < 50) tick();
    end
    check({tag, " done_cycle_a"}, 64'(dc_a), 64'd43);
    check({tag, " done_cycle_b"}, 64'(dc_b), 64'd43);
    check({tag, " done_count_a"}, 64'(dn_a), 64'd1);
    check({tag, " busy_low_a"}, 64'(bl_a), 64'd44);
    check({tag, " busy_low_b"}, 64'(bl_b), 64'd44);
    if (tag == "peak") begin
      check({tag, " max_pos_a"}, 64'(mx_a), 64'd40);
      check({tag, " max_pos_b"}, 64'(mx_b), 64'd40);
    end
  endtask

  initial begin
    int dseen;

    // Reset held for 5 cycles.
    RST = 1'b1;
    repeat (5) tick();
    check("rst pos_a", 64'(pos_a), {32'(CENTER), 32'(CENTER)});
    check("rst pos_b", 64'(pos_b), {32'(CENTER), 32'(CENTER)});
    check("rst maxv", 64'(maxv_a), 64'd0);
    check("rst busy", 64'(busy_a), 64'd0);
    check("rst done", 64'(done_a), 64'd0);
    check("rst aborted", 64'(abt_a), 64'd0);
    check("rst axis", 64'(ax_a), 64'd0);
    RST = 1'b0;
    tick();

    // Peak sweep.
    mode = 0;
    run_sweep("peak");
    check("peak pos_a", 64'(pos_a), {32'd40, 32'd20});
    check("peak pos_b", 64'(pos_b), {32'd40, 32'd20});
    check("peak maxv_a", 64'(maxv_a), 64'({12'd700, 12'd900}));
    check("peak maxv_b", 64'(maxv_b), 64'({12'd700, 12'd900}));

    // Flat input: ties keep the first (lowest) position.
    mode = 1;
    run_sweep("flat");
    check("flat pos_a", 64'(pos_a), {32'd0, 32'd0});
    check("flat maxv_a", 64'(maxv_a), 64'({12'd512, 12'd512}));

    // 100,103,110: same final result with or without hysteresis.
    mode = 2;
    run_sweep("hyst3");
    check("hyst3 pos_a", 64'(pos_a), {32'd0, 32'd20});
    check("hyst3 maxv_a", 64'(maxv_a), 64'({12'd0, 12'd110}));

    // 100,103 only: hysteresis rejects the 3-LSB improvement.
    mode = 3;
    run_sweep("hyst2");
`ifdef MAX_HYST_EN
    check("hyst2 pos_a", 64'(pos_a), {32'd0, 32'd0});
    check("hyst2 maxv_a", 64'(maxv_a), 64'({12'd0, 12'd100}));
`else
    check("hyst2 pos_a", 64'(pos_a), {32'd0, 32'd10});
    check("hyst2 maxv_a", 64'(maxv_a), 64'({12'd0, 12'd103}));
`endif

    // Abort during axis 1 SETTLE with pre-start positions at CENTER.
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    tick();
    mode = 0;
    start = 1'b1;
    tick();                      // edge 0, now in cycle 1
    start = 1'b0;
    repeat (22) tick();          // now in cycle 23: axis 1 SETTLE
    check("pre_abort axis", 64'(ax_a), 64'd1);
    check("pre_abort busy", 64'(busy_a), 64'd1);
    check("pre_abort pos_a", 64'(pos_a), {32'd0, 32'd20});
    check("pre_abort maxv_a", 64'(maxv_a), 64'({12'd0, 12'd900}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort pos_a", 64'(pos_a), {32'(CENTER), 32'(CENTER)});
    check("abort pos_b", 64'(pos_b), {32'(CENTER), 32'(CENTER)});
    check("abort pulse", 64'(abt_a), 64'd1);
    check("abort busy", 64'(busy_a), 64'd0);
    check("abort axis", 64'(ax_a), 64'd0);
    check("abort maxv_a", 64'(maxv_a), 64'({12'd0, 12'd900}));
    dseen = 0;
    if (done_a) dseen++;
    tick();
    check("abort pulse_end", 64'(abt_a), 64'd0);
    for (int i = 0; i < 30; i++) begin
      if (done_a || busy_a) dseen++;
      tick();
    end
    check("abort no_done", 64'(dseen), 64'd0);

    // start and abort together in IDLE: nothing happens.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort busy", 64'(busy_a), 64'd0);
    check("idle_abort pulse", 64'(abt_a), 64'd0);
    tick();
    check("idle_abort stay", 64'(busy_a), 64'd0);
    check("idle_abort pos_a", 64'(pos_a), {32'(CENTER), 32'(CENTER)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
